// File: rtl/register_file_sb.sv
// Register bank with two registered read ports, write-to-read bypass,
// optional hardwired zero register and a per-register busy scoreboard.
module register_file_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  input  logic              write,
  input  logic [ADDR_W-1:0] dr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_dr,
  output logic [DATA_W-1:0] rData1,
  output logic [DATA_W-1:0] rData2,
  output logic              busy1,
  output logic              busy2,
  output logic              busy_any
);

  localparam int              IDX_W  = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0] NREG_L = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [NUM_REGS-1:0] ONE_L = {{(NUM_REGS - 1){1'b0}}, 1'b1};

  logic [DATA_W-1:0]   regfile_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic [NUM_REGS-1:0] clr_mask_s;
  logic [NUM_REGS-1:0] set_mask_s;
  logic                wr_ok_s;
  logic                iss_ok_s;
  logic [DATA_W-1:0]   rd1_nxt_s;
  logic [DATA_W-1:0]   rd2_nxt_s;
  logic                bsy1_nxt_s;
  logic                bsy2_nxt_s;

  // In-range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    addr_ok = ({1'b0, a} < NREG_L) && !((ZERO_REG != 0) && (a == {ADDR_W{1'b0}}));
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
    idx = a[IDX_W-1:0];
  endfunction

  assign wr_ok_s    = write && addr_ok(dr);
  assign iss_ok_s   = issue && addr_ok(issue_dr);
  assign clr_mask_s = wr_ok_s  ? (ONE_L << idx(dr))       : {NUM_REGS{1'b0}};
  assign set_mask_s = iss_ok_s ? (ONE_L << idx(issue_dr)) : {NUM_REGS{1'b0}};
  // Set is applied after clear so a new producer wins over a retiring one.
  assign busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;

  // Next read data and busy flags for both ports.
  always_comb begin
    rd1_nxt_s  = {DATA_W{1'b0}};
    rd2_nxt_s  = {DATA_W{1'b0}};
    bsy1_nxt_s = 1'b0;
    bsy2_nxt_s = 1'b0;
    if (!addr_ok(sr1)) begin
      rd1_nxt_s  = {DATA_W{1'b0}};
      bsy1_nxt_s = 1'b0;
    end else begin
      if ((BYPASS != 0) && wr_ok_s && (dr == sr1)) begin
        rd1_nxt_s = wrData;
      end else begin
        rd1_nxt_s = regfile_r[idx(sr1)];
      end
      bsy1_nxt_s = (BYPASS != 0) ? busy_nxt_s[idx(sr1)] : busy_r[idx(sr1)];
    end
    if (!addr_ok(sr2)) begin
      rd2_nxt_s  = {DATA_W{1'b0}};
      bsy2_nxt_s = 1'b0;
    end else begin
      if ((BYPASS != 0) && wr_ok_s && (dr == sr2)) begin
        rd2_nxt_s = wrData;
      end else begin
        rd2_nxt_s = regfile_r[idx(sr2)];
      end
      bsy2_nxt_s = (BYPASS != 0) ? busy_nxt_s[idx(sr2)] : busy_r[idx(sr2)];
    end
  end

  // Storage, scoreboard and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regfile_r[i] <= {DATA_W{1'b0}};
      end
      busy_r   <= {NUM_REGS{1'b0}};
      rData1   <= {DATA_W{1'b0}};
      rData2   <= {DATA_W{1'b0}};
      busy1    <= 1'b0;
      busy2    <= 1'b0;
      busy_any <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        regfile_r[idx(dr)] <= wrData;
      end
      busy_r   <= busy_nxt_s;
      rData1   <= rd1_nxt_s;
      rData2   <= rd2_nxt_s;
      busy1    <= bsy1_nxt_s;
      busy2    <= bsy2_nxt_s;
      busy_any <= |busy_nxt_s;
    end
  end

endmodule
